// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: oversamples ps2_clk, deframes 11-bit frames and
// queues valid scan codes in an 8-entry FIFO popped with an active-low request.
module ps2_keyboard (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow
);

  logic [2:0] ps2_clk_sync;
  logic       sampling;
  logic [9:0] buffer;
  logic [3:0] count;
  logic [7:0] fifo [8];
  logic [2:0] w_ptr;
  logic [2:0] r_ptr;
  logic [3:0] occ;
  logic       frame_good;
  logic       fifo_full;
  logic       pop;
  logic       push;

  // Falling edge of the synchronized PS/2 clock marks a bit to capture.
  assign sampling   = ps2_clk_sync[2] & ~ps2_clk_sync[1];
  assign frame_good = sampling && (count == 4'd10) && !buffer[0] && ps2_data
                      && (^buffer[9:1]);
  assign fifo_full  = (occ == 4'd8);
  assign ready      = (occ != 4'd0);
  assign pop        = ready && !nextdata_n;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the frame.
  assign push       = frame_good && (!fifo_full || pop);
  assign data       = fifo[r_ptr];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_clk_sync <= 3'b111;
      count        <= 4'd0;
    end else begin
      ps2_clk_sync <= {ps2_clk_sync[1:0], ps2_clk};
      if (sampling) begin
        if (count == 4'd10) count <= 4'd0;
        else                count <= count + 4'd1;
      end
    end
  end

  // Frame bits are pure data; the counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (sampling && (count != 4'd10)) buffer[count] <= ps2_data;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 8; i++) fifo[i] <= 8'h00;
      w_ptr    <= 3'd0;
      r_ptr    <= 3'd0;
      occ      <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        fifo[w_ptr] <= buffer[8:1];
        w_ptr       <= w_ptr + 3'd1;
      end
      if (pop) r_ptr <= r_ptr + 3'd1;
      case ({push, pop})
        2'b10:   occ <= occ + 4'd1;
        2'b01:   occ <= occ - 4'd1;
        default: occ <= occ;
      endcase
      if (frame_good && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboard bench for ps2_keyboard: bit-bangs PS/2 frames and checks the FIFO.
module tb_ps2_keyboard;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] data;
  logic       ready;
  logic       overflow;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       model_ovf = 1'b0;

  ps2_keyboard dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .data(data), .ready(ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  // Drives nbits of a frame; optionally pops exactly during the stop-bit push cycle.
  task automatic send_bits(input logic [10:0] frame, input int nbits, input bit pop_last);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = frame[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      if (pop_last && i == 10) begin
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() == 0 || data !== exp_q[0]) begin
          bad++;
          $display("FAIL stop_pop_data actual=%h required=%h", data,
                   (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
        end
        nextdata_n = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(negedge clk) nextdata_n = 1'b1;
        repeat (7) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input bit pop_last);
    send_bits(make_frame(b, bad_par), 11, pop_last);
    if (!bad_par) begin
      if (exp_q.size() < 8) exp_q.push_back(b);
      else                  model_ovf = 1'b1;
    end
  endtask

  task automatic do_pop(input string name);
    @(negedge clk);
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready actual=%b required=1", name, ready);
    end
    total++;
    if (exp_q.size() == 0 || data !== exp_q[0]) begin
      bad++;
      $display("FAIL %s_data actual=%h required=%h", name, data,
               (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
    end
    nextdata_n = 1'b0;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    @(negedge clk) nextdata_n = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk) clrn = 1'b0;
    exp_q.delete();
    model_ovf = 1'b0;
    @(negedge clk) clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready actual=%b required=0", ready); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow actual=%b required=0", overflow); end
    total++;
    if (data !== 8'h00) begin bad++; $display("FAIL reset_data actual=%h required=00", data); end
    clrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b0);
    total++;
    if (overflow !== model_ovf) begin bad++; $display("FAIL single_overflow actual=%b required=%b", overflow, model_ovf); end
    do_pop("single");
    total++;
    if (ready !== (exp_q.size() != 0)) begin bad++; $display("FAIL single_empty actual=%b required=%b", ready, exp_q.size() != 0); end
  endtask

  task automatic test_break();
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    do_pop("break_f0");
    do_pop("break_1c");
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL break_empty actual=%b required=0", ready); end
  endtask

  task automatic test_parity();
    send_frame(8'h1C, 1'b1, 1'b0);
    total++;
    if (ready !== (exp_q.size() != 0)) begin bad++; $display("FAIL parity_ready actual=%b required=%b", ready, exp_q.size() != 0); end
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL parity_overflow actual=%b required=0", overflow); end
    send_frame(8'h23, 1'b0, 1'b0);
    do_pop("parity_next");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
    total++;
    if (overflow !== model_ovf) begin bad++; $display("FAIL ovf_flag actual=%b required=%b", overflow, model_ovf); end
    for (int i = 0; i < 8; i++) do_pop("ovf_drain");
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL ovf_empty actual=%b required=0", ready); end
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky actual=%b required=1", overflow); end
    apply_reset();
    total++;
    if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear actual=%b required=0", overflow); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h48, 1'b0, 1'b1);
    @(negedge clk);
    total++;
    if (overflow !== model_ovf) begin bad++; $display("FAIL fullpp_overflow actual=%b required=%b", overflow, model_ovf); end
    for (int i = 0; i < 8; i++) do_pop("fullpp_drain");
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL fullpp_empty actual=%b required=0", ready); end
  endtask

  task automatic test_held_pop();
    int cycles;
    send_frame(8'h31, 1'b0, 1'b0);
    send_frame(8'h32, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0);
    @(negedge clk);
    nextdata_n = 1'b0;
    cycles = 0;
    while (ready === 1'b1 && cycles < 10) begin
      total++;
      if (exp_q.size() == 0 || data !== exp_q[0]) begin
        bad++;
        $display("FAIL held_data actual=%h required=%h", data, (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
      cycles++;
    end
    nextdata_n = 1'b1;
    total++;
    if (cycles != 3) begin bad++; $display("FAIL held_cycles actual=%0d required=3", cycles); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h55, 1'b0, 1'b0);
    send_bits(make_frame(8'h77, 1'b0), 5, 1'b0);
    @(negedge clk) clrn = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL midrst_ready actual=%b required=0", ready); end
    exp_q.delete();
    model_ovf = 1'b0;
    @(negedge clk) clrn = 1'b1;
    send_frame(8'h1B, 1'b0, 1'b0);
    do_pop("midrst_next");
    total++;
    if (ready !== 1'b0) begin bad++; $display("FAIL midrst_empty actual=%b required=0", ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_break();
    test_parity();
    test_overflow();
    test_full_push_pop();
    test_held_pop();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
